// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution pipe.
// Holds the ALU opcode enum, the control bundle carried alongside each entry,
// and the default lane count and element width.
package vec_pkg;

  localparam int unsigned DefLanes = 8;
  localparam int unsigned DefN     = 20;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpSll = 3'd5,
    OpSrl = 3'd6,
    OpMul = 3'd7
  } alu_op_e;

  // {RegWrite, MemtoReg, MemWrite}
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ctrl_t;

endpackage

// File: rtl/vec_exec_pipe_if.sv
// Handshake bundle for vec_exec_pipe.
// Producer side: validIn/readyIn, opA, opB, ALUControl, laneMask, tagIn, ctrlIn.
// Consumer side: validOut/readyOut, result, tagOut, ctrlOut, plus occupancy.
// Modports: slave (the pipe), master (whoever drives and consumes it).
interface vec_exec_pipe_if
  import vec_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned N     = DefN,
  parameter int unsigned TAGW  = 4
);

  logic                       validIn;
  logic                       readyIn;
  logic [LANES-1:0][N-1:0]    opA;
  logic [LANES-1:0][N-1:0]    opB;
  logic [2:0]                 ALUControl;
  logic [LANES-1:0]           laneMask;
  logic [TAGW-1:0]            tagIn;
  ctrl_t                      ctrlIn;

  logic                       validOut;
  logic                       readyOut;
  logic [LANES-1:0][N-1:0]    result;
  logic [TAGW-1:0]            tagOut;
  ctrl_t                      ctrlOut;
  logic [2:0]                 occupancy;

  modport slave (
    input  validIn, opA, opB, ALUControl, laneMask, tagIn, ctrlIn, readyOut,
    output readyIn, validOut, result, tagOut, ctrlOut, occupancy
  );

  modport master (
    output validIn, opA, opB, ALUControl, laneMask, tagIn, ctrlIn, readyOut,
    input  readyIn, validOut, result, tagOut, ctrlOut, occupancy
  );

endinterface

// File: rtl/vec_lane_alu.sv
// Single-lane ALU for vec_exec_pipe (purely combinational).
// Ports: a_i/b_i operands, op_i opcode, en_i lane enable (0 passes a_i through),
// res_o lane result.
// Build option: VEC_SAT_EN makes ADD/SUB saturate as signed N-bit values;
// without it they wrap modulo 2^N.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int unsigned N = DefN
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  alu_op_e      op_i,
  input  logic         en_i,
  output logic [N-1:0] res_o
);

  localparam int unsigned ShW = (N > 1) ? $clog2(N) : 1;

  logic [ShW-1:0] shamt;
  logic           shift_oob;
  logic [N-1:0]   add_res;
  logic [N-1:0]   sub_res;
  logic [N-1:0]   op_res;

  assign shamt     = b_i[ShW-1:0];
  // Shift field can encode amounts >= N when N is not a power of two.
  assign shift_oob = 32'(shamt) >= N;

`ifdef VEC_SAT_EN
  logic [N:0] sum_ext;
  logic [N:0] dif_ext;

  // One extra sign bit: overflow when the top two bits disagree, and the
  // top bit then gives the direction of the clamp.
  always_comb begin
    sum_ext = {a_i[N-1], a_i} + {b_i[N-1], b_i};
    dif_ext = {a_i[N-1], a_i} - {b_i[N-1], b_i};
    if (sum_ext[N] != sum_ext[N-1]) begin
      add_res = {sum_ext[N], {(N-1){~sum_ext[N]}}};
    end else begin
      add_res = sum_ext[N-1:0];
    end
    if (dif_ext[N] != dif_ext[N-1]) begin
      sub_res = {dif_ext[N], {(N-1){~dif_ext[N]}}};
    end else begin
      sub_res = dif_ext[N-1:0];
    end
  end
`else
  assign add_res = a_i + b_i;
  assign sub_res = a_i - b_i;
`endif

  always_comb begin
    op_res = '0;
    unique case (op_i)
      OpAdd: op_res = add_res;
      OpSub: op_res = sub_res;
      OpAnd: op_res = a_i & b_i;
      OpOr:  op_res = a_i | b_i;
      OpXor: op_res = a_i ^ b_i;
      OpSll: op_res = shift_oob ? '0 : (a_i << shamt);
      OpSrl: op_res = shift_oob ? '0 : (a_i >> shamt);
      OpMul: op_res = a_i * b_i;
      default: op_res = '0;
    endcase
  end

  assign res_o = en_i ? op_res : a_i;

endmodule

// File: rtl/vec_exec_pipe.sv
// Vector execution pipe: computes a LANES-wide ALU operation in stage 1 and
// carries the result, tag and control bits through DEPTH register stages with
// valid/ready handshakes on both ends. Empty stages collapse, so a stalled
// output only blocks once every stage is full.
// Ports: CLK, RST (async active-low), CLR (sync flush), bus (slave modport of
// vec_exec_pipe_if carrying the input and output bundles and occupancy).
// Build option: VEC_SAT_EN selects saturating ADD/SUB in vec_lane_alu.
module vec_exec_pipe
  import vec_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned N     = DefN,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned TAGW  = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CLR,
  vec_exec_pipe_if.slave  bus
);

  typedef logic [LANES-1:0][N-1:0] vec_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  vec_t             data_q [DEPTH];
  vec_t             data_d [DEPTH];
  logic [TAGW-1:0]  tag_q  [DEPTH];
  logic [TAGW-1:0]  tag_d  [DEPTH];
  ctrl_t            ctrl_q [DEPTH];
  ctrl_t            ctrl_d [DEPTH];

  // free[k]: stage k can take a new entry at the next edge (empty or draining).
  logic [DEPTH-1:0] free;
  logic             free_chain;
  logic             accept;
  vec_t             alu_res;
  logic [2:0]       occ;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_lane_alu #(
      .N (N)
    ) u_lane_alu (
      .a_i   (bus.opA[i]),
      .b_i   (bus.opB[i]),
      .op_i  (alu_op_e'(bus.ALUControl)),
      .en_i  (bus.laneMask[i]),
      .res_o (alu_res[i])
    );
  end

  // Walk from the output back to stage 1 so a hole anywhere downstream lets
  // everything behind it move.
  always_comb begin
    free       = '0;
    free_chain = bus.readyOut;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      free_chain = !valid_q[k] || free_chain;
      free[k]    = free_chain;
    end
  end

  assign accept = bus.validIn && free[0] && !CLR;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    ctrl_d  = ctrl_q;
    if (free[0]) begin
      valid_d[0] = accept;
      if (accept) begin
        data_d[0] = alu_res;
        tag_d[0]  = bus.tagIn;
        ctrl_d[0] = bus.ctrlIn;
      end
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      if (free[k]) begin
        valid_d[k] = valid_q[k-1];
        // Payload only moves with a valid entry; empty stages keep stale data.
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          tag_d[k]  = tag_q[k-1];
          ctrl_d[k] = ctrl_q[k-1];
        end
      end
    end
    if (CLR) begin
      valid_d = '0;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      occ = occ + 3'(valid_q[k]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
        ctrl_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= data_d[k];
        tag_q[k]  <= tag_d[k];
        ctrl_q[k] <= ctrl_d[k];
      end
    end
  end

  assign bus.readyIn   = free[0];
  assign bus.validOut  = valid_q[DEPTH-1];
  assign bus.result    = data_q[DEPTH-1];
  assign bus.tagOut    = tag_q[DEPTH-1];
  assign bus.ctrlOut   = ctrl_q[DEPTH-1];
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_vec_exec_pipe.sv
// Self-checking bench for vec_exec_pipe (LANES=8, N=20, DEPTH=3).
// A queue-based model tracks every accepted bundle with its accept cycle; the
// pipe is expected to behave as a FIFO whose head becomes visible DEPTH cycles
// after acceptance and which refuses input only when DEPTH entries are held
// and the consumer is stalled.
module tb_vec_exec_pipe;

  localparam int unsigned LANES = 8;
  localparam int unsigned N     = 20;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned TAGW  = 4;

  typedef logic [LANES-1:0][N-1:0] vec_t;
  typedef struct {
    vec_t            res;
    logic [TAGW-1:0] tag;
    logic [2:0]      ctrl;
    int              cyc;
  } exp_t;

  logic CLK, RST, CLR;
  exp_t q[$];
  int   cyc;
  int   checks, errors;

  vec_exec_pipe_if #(.LANES(LANES), .N(N), .TAGW(TAGW)) bus ();

  vec_exec_pipe #(
    .LANES (LANES),
    .N     (N),
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] ref_lane(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [2:0] op);
    longint m, ua, ub, r;
    int     amt;
`ifdef VEC_SAT_EN
    longint sa, sb;
`endif
    m   = longint'(1) << N;
    ua  = longint'(a);
    ub  = longint'(b);
    amt = int'(ub % 32);
    r   = 0;
    case (op)
      3'd0: r = ua + ub;
      3'd1: r = ua - ub + m;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (amt >= int'(N)) ? 0 : (ua << amt);
      3'd6: r = (amt >= int'(N)) ? 0 : (ua >> amt);
      default: r = ua * ub;
    endcase
`ifdef VEC_SAT_EN
    if (op == 3'd0 || op == 3'd1) begin
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      r  = (op == 3'd0) ? sa + sb : sa - sb;
      if (r > m / 2 - 1) r = m / 2 - 1;
      if (r < -(m / 2)) r = -(m / 2);
      if (r < 0) r = r + m;
    end
`endif
    return r[N-1:0];
  endfunction

  function automatic vec_t ref_vec(input vec_t a, input vec_t b, input logic [2:0] op,
                                   input logic [LANES-1:0] mask);
    vec_t r;
    for (int i = 0; i < int'(LANES); i++) begin
      r[i] = mask[i] ? ref_lane(a[i], b[i], op) : a[i];
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < int'(LANES); i++) v[i] = N'($urandom);
    return v;
  endfunction

  function automatic vec_t splat(input logic [N-1:0] x);
    vec_t v;
    for (int i = 0; i < int'(LANES); i++) v[i] = x;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input vec_t a, input vec_t b, input logic [2:0] op,
                       input logic [LANES-1:0] m, input logic [TAGW-1:0] t, input logic [2:0] c);
    bus.validIn    = v;
    bus.opA        = a;
    bus.opB        = b;
    bus.ALUControl = op;
    bus.laneMask   = m;
    bus.tagIn      = t;
    bus.ctrlIn     = c;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, rand_vec(), rand_vec(), 3'($urandom), LANES'($urandom), TAGW'($urandom),
          3'($urandom));
  endtask

  // One clock cycle: check the handshake outputs against the model, retire or
  // record bundles, then advance to 1 time unit past the next rising edge.
  task automatic step();
    logic exp_ready, exp_valid;
    exp_t e;
    @(negedge CLK);
    exp_ready = (q.size() < int'(DEPTH)) || bus.readyOut;
    exp_valid = 1'b0;
    if (q.size() > 0) exp_valid = (cyc - q[0].cyc) >= int'(DEPTH);
    checks++;
    if (bus.readyIn !== exp_ready) begin
      errors++;
      $display("FAIL readyIn cyc %0d got %b want %b", cyc, bus.readyIn, exp_ready);
    end
    checks++;
    if (bus.validOut !== exp_valid) begin
      errors++;
      $display("FAIL validOut cyc %0d got %b want %b", cyc, bus.validOut, exp_valid);
    end
    checks++;
    if (bus.occupancy !== 3'(q.size())) begin
      errors++;
      $display("FAIL occupancy cyc %0d got %0d want %0d", cyc, bus.occupancy, q.size());
    end
    if (exp_valid && bus.readyOut) begin
      e = q.pop_front();
      checks++;
      if (bus.result !== e.res || bus.tagOut !== e.tag || bus.ctrlOut !== e.ctrl) begin
        errors++;
        $display("FAIL out_bundle cyc %0d got %h/%h/%h want %h/%h/%h", cyc, bus.result,
                 bus.tagOut, bus.ctrlOut, e.res, e.tag, e.ctrl);
      end
    end
    if (CLR) begin
      q.delete();
    end else if (bus.validIn && exp_ready) begin
      e.res  = ref_vec(bus.opA, bus.opB, bus.ALUControl, bus.laneMask);
      e.tag  = bus.tagIn;
      e.ctrl = bus.ctrlIn;
      e.cyc  = cyc;
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Presents one bundle to an empty pipe and waits (bounded) for it to emerge.
  task automatic send_one(input vec_t a, input vec_t b, input logic [2:0] op,
                          input logic [LANES-1:0] m, input logic [TAGW-1:0] t,
                          output vec_t res, output logic [TAGW-1:0] tag, output int lat);
    bus.readyOut = 1'b1;
    drive(1'b1, a, b, op, m, t, 3'b101);
    step();
    bus.validIn = 1'b0;
    lat = 1;
    while (bus.validOut !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    res = bus.result;
    tag = bus.tagOut;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    CLR = 1'b0;
    bus.readyOut = 1'b1;
    drive(1'b0, '0, '0, 3'd0, '0, '0, 3'd0);
    #12;
    checks++;
    if (bus.validOut !== 1'b0 || bus.occupancy !== 3'd0 || bus.result !== '0 ||
        bus.tagOut !== '0 || bus.ctrlOut !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b occ=%0d res=%h tag=%h ctrl=%h want all zero",
               bus.validOut, bus.occupancy, bus.result, bus.tagOut, bus.ctrlOut);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    q.delete();
    step();
    checks++;
    if (bus.readyIn !== 1'b1) begin
      errors++;
      $display("FAIL reset_readyIn got %b want 1", bus.readyIn);
    end
  endtask

  task automatic test_add_basic();
    vec_t a, b, res, want;
    logic [TAGW-1:0] tag;
    int lat;
    for (int i = 0; i < int'(LANES); i++) begin
      a[i]    = N'(i);
      b[i]    = N'(1);
      want[i] = N'(i + 1);
    end
    send_one(a, b, 3'd0, 8'hFF, 4'h5, res, tag, lat);
    checks++;
    if (lat !== int'(DEPTH)) begin
      errors++;
      $display("FAIL add_latency got %0d want %0d", lat, DEPTH);
    end
    checks++;
    if (res !== want) begin
      errors++;
      $display("FAIL add_result got %h want %h", res, want);
    end
    checks++;
    if (tag !== 4'h5) begin
      errors++;
      $display("FAIL add_tag got %h want 5", tag);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] av[4], bv[4], wv[4];
    logic [2:0]   ov[4];
    vec_t res;
    logic [TAGW-1:0] tag;
    int lat;
    av[0] = 20'hFFFFF; bv[0] = 20'h00001; ov[0] = 3'd0; wv[0] = 20'h00000;
    av[1] = 20'h00000; bv[1] = 20'h00001; ov[1] = 3'd1; wv[1] = 20'hFFFFF;
    av[2] = 20'h7FFFF; bv[2] = 20'h00001; ov[2] = 3'd0;
    av[3] = 20'h80000; bv[3] = 20'h00001; ov[3] = 3'd1;
`ifdef VEC_SAT_EN
    wv[2] = 20'h7FFFF;
    wv[3] = 20'h80000;
`else
    wv[2] = 20'h80000;
    wv[3] = 20'h7FFFF;
`endif
    for (int k = 0; k < 4; k++) begin
      send_one(splat(av[k]), splat(bv[k]), ov[k], 8'hFF, TAGW'(k), res, tag, lat);
      checks++;
      if (res !== splat(wv[k]) || lat !== int'(DEPTH)) begin
        errors++;
        $display("FAIL wrap_case%0d got %h lat %0d want %h lat %0d", k, res[0], lat, wv[k],
                 DEPTH);
      end
    end
  endtask

  task automatic test_shift_mask();
    vec_t a, b, res, want;
    logic [TAGW-1:0] tag;
    int lat;
    send_one(splat(20'h00001), splat(20'd4), 3'd5, 8'hFF, 4'h1, res, tag, lat);
    checks++;
    if (res !== splat(20'h00010)) begin
      errors++;
      $display("FAIL sll4 got %h want all 00010", res);
    end
    send_one(splat(20'h00001), splat(20'd25), 3'd5, 8'hFF, 4'h2, res, tag, lat);
    checks++;
    if (res !== '0) begin
      errors++;
      $display("FAIL sll25 got %h want 0", res);
    end
    send_one(splat(20'h80000), splat(20'd20), 3'd6, 8'hFF, 4'h3, res, tag, lat);
    checks++;
    if (res !== '0) begin
      errors++;
      $display("FAIL srl20 got %h want 0", res);
    end
    a = rand_vec();
    b = rand_vec();
    for (int i = 0; i < int'(LANES); i++) begin
      want[i] = (i < 4) ? N'(longint'(a[i]) * longint'(b[i])) : a[i];
    end
    send_one(a, b, 3'd7, 8'h0F, 4'h4, res, tag, lat);
    checks++;
    if (res !== want) begin
      errors++;
      $display("FAIL mul_mask got %h want %h", res, want);
    end
  endtask

  task automatic test_backpressure();
    int seen, first, last;
    bus.readyOut = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_rand(1'b1);
      step();
    end
    checks++;
    if (bus.occupancy !== 3'd3 || bus.readyIn !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got occ=%0d readyIn=%b want occ=3 readyIn=0", bus.occupancy,
               bus.readyIn);
    end
    bus.validIn  = 1'b0;
    bus.readyOut = 1'b1;
    seen  = 0;
    first = -1;
    last  = -1;
    for (int j = 0; j < 10; j++) begin
      if (bus.validOut === 1'b1) begin
        seen++;
        if (first < 0) first = j;
        last = j;
      end
      step();
    end
    checks++;
    if (seen != 3 || last - first != 2) begin
      errors++;
      $display("FAIL bp_drain got %0d outputs span %0d want 3 outputs span 2", seen,
               last - first);
    end
  endtask

  task automatic test_clr();
    int seen;
    bus.readyOut = 1'b0;
    drive(1'b1, rand_vec(), rand_vec(), 3'd0, 8'hFF, 4'hA, 3'd1);
    step();
    drive(1'b1, rand_vec(), rand_vec(), 3'd1, 8'hFF, 4'hB, 3'd2);
    step();
    drive(1'b1, rand_vec(), rand_vec(), 3'd2, 8'hFF, 4'hC, 3'd3);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    bus.validIn = 1'b0;
    checks++;
    if (bus.validOut !== 1'b0 || bus.occupancy !== 3'd0) begin
      errors++;
      $display("FAIL clr_flush got v=%b occ=%0d want v=0 occ=0", bus.validOut, bus.occupancy);
    end
    bus.readyOut = 1'b1;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      if (bus.validOut === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL clr_leak got %0d outputs want 0", seen);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive_rand(($urandom % 4) != 0);
      bus.readyOut = ($urandom % 3) != 0;
      CLR = 1'b0;
      if (($urandom % 50) == 0) begin
        CLR = 1'b1;
        bus.readyOut = 1'b0;
      end
      step();
    end
    CLR = 1'b0;
  endtask

  task automatic test_reset_midstream();
    vec_t res;
    logic [TAGW-1:0] tag;
    int lat;
    bus.readyOut = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_rand(1'b1);
      step();
    end
    RST = 1'b0;
    #1;
    checks++;
    if (bus.validOut !== 1'b0 || bus.occupancy !== 3'd0 || bus.result !== '0 ||
        bus.tagOut !== '0 || bus.ctrlOut !== 3'd0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b occ=%0d res=%h tag=%h want all zero",
               bus.validOut, bus.occupancy, bus.result, bus.tagOut);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    q.delete();
    send_one(splat(20'h00003), splat(20'h00004), 3'd4, 8'hFF, 4'h9, res, tag, lat);
    checks++;
    if (lat !== int'(DEPTH) || res !== splat(20'h00007) || tag !== 4'h9) begin
      errors++;
      $display("FAIL midreset_first got lat %0d res %h tag %h want lat %0d res 7s tag 9",
               lat, res[0], tag, DEPTH);
    end
  endtask

  task automatic test_drain();
    bus.validIn  = 1'b0;
    bus.readyOut = 1'b1;
    repeat (6) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding want 0", q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_add_basic();
    test_wrap();
    test_shift_mask();
    test_backpressure();
    test_clr();
    test_random();
    test_drain();
    test_reset_midstream();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
